fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Parametrised next-PC generator for the instruction frontend. It tracks the fetch PC and issues address requests to the I$ with a valid/ready handshake. It selects the next fetch address from N priority-ordered redirect sources (commit, exception, eret, debug, mispredict, …), fetch replay, branch prediction or sequential advance. It also drives I$ kill signals and a saturating redirect counter. The fetch block size and the number of redirect channels are configurable.

Parameters:
VLEN, 39, virtual address width in bits.
FETCH_BYTES, 4, fetch block size in bytes; legal values 4, 8, 16.
NR_REDIRECT, 4, number of redirect channels; a higher index has higher priority.
CNT_W, 16, width of the redirect counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
boot_addr_i  in  VLEN  PC loaded on the first cycle after reset
halt_i  in  1  suppress fetch requests; state is kept
flush_i  in  1  frontend flush; kills the I$ pipeline
redirect_valid_i  in  NR_REDIRECT  per-channel redirect request
redirect_addr_i  in  NR_REDIRECT*VLEN  per-channel target; channel k occupies [k*VLEN +: VLEN]
replay_i  in  1  re-fetch request from the instruction queue
replay_addr_i  in  VLEN  replay address
bp_valid_i  in  1  predicted-taken branch in the current fetch
bp_addr_i  in  VLEN  predicted target
fetch_ready_i  in  1  instruction queue can accept data
req_o  out  1  I$ request valid
vaddr_o  out  VLEN  I$ request address
req_ready_i  in  1  I$ accepted the request
kill_s1_o  out  1  kill I$ stage 1
kill_s2_o  out  1  kill I$ stage 2
redirect_cnt_o  out  CNT_W  saturating count of redirects taken

Behaviour:
- Reset (asynchronous, active-low rst_ni, clock clk_i):
  - State = BOOT, PC register = 0, redirect_cnt_o = 0.
  - req_o = 0, kill_s1_o = 0, kill_s2_o = 0, vaddr_o = 0.
- State BOOT, one cycle:
  - vaddr_o = boot_addr_i, req_o = 0, PC ← boot_addr_i.
  - Next state: HALT if halt_i, else RUN.
- State RUN:
  - vaddr_o = PC.
  - req_o = fetch_ready_i & ~flush_i & ~halt_i.
  - A request is accepted when req_o & req_ready_i.
- State HALT:
  - req_o = 0; vaddr_o = PC.
  - Leaves to RUN on the cycle after halt_i deasserts.
  - Redirects are still applied to PC while in HALT.
- Kill signals are combinational on the same cycle:
  - kill_s1_o = |redirect_valid_i | flush_i | replay_i.
  - kill_s2_o = kill_s1_o | bp_valid_i.
- Next-PC priority (highest first), register update on the next edge:
  1. Highest-index valid redirect channel: PC ← redirect_addr_i[k].
  2. replay_i: PC ← replay_addr_i.
  3. bp_valid_i: PC ← bp_addr_i.
  4. Accepted request: PC ← (PC & ~(FETCH_BYTES-1)) + FETCH_BYTES.
  5. Otherwise: PC holds.
- Redirect latency: a redirect in cycle N gives vaddr_o = target in cycle N+1. No request for the stale PC may be accepted after cycle N.
- An unaccepted request (req_o=1, req_ready_i=0) keeps vaddr_o stable unless one of sources 1–3 fires. Those sources override the pending address, and kill_s1_o marks the drop.
- Addresses from sources 1–3 are used unaligned; only the sequential step aligns to FETCH_BYTES.
- Arithmetic is modulo 2^VLEN: the sequential step from the last block wraps to 0.
- flush_i without a redirect: PC holds and req_o = 0 that cycle.
- Counter:
  - redirect_cnt_o increments by 1 in each cycle with any redirect_valid_i.
  - Simultaneous channels count once.
  - Saturates at 2^CNT_W-1 and never wraps.
- A redirect or replay arriving in BOOT is ignored; boot_addr_i wins.
- Reset asserted mid-operation returns immediately to the reset values above, regardless of any in-flight handshake.

Test Plan:
- Reset release with boot_addr_i=0x8000_0000, FETCH_BYTES=8, fetch_ready_i=1, req_ready_i=1 → cycle 1: req_o=0, vaddr_o=0x8000_0000. Then vaddr_o=0x8000_0000, 0x8000_0008, 0x8000_0010 on consecutive cycles.
- Unaligned redirect on channel 1 to 0x1006, then sequential fetch → vaddr_o=0x1006, then 0x1008. kill_s1_o=1 in the redirect cycle.
- Channels 0 and 3 valid together (targets 0x100/0x300) plus replay_i and bp_valid_i in the same cycle → next vaddr_o=0x300. redirect_cnt_o increments by exactly 1.
- req_ready_i=0 for 3 cycles with PC=0x2000, then bp_valid_i=1 to 0x4000 → vaddr_o stays 0x2000 for 3 cycles, then 0x4000. kill_s2_o=1, kill_s1_o=0.
- PC=2^VLEN-FETCH_BYTES, accepted request → next vaddr_o=0. Separately, halt_i=1 plus a redirect to 0x500 → req_o=0; after halt_i drops, the first request is at 0x500.
- CNT_W=2 with 5 redirect cycles → redirect_cnt_o reads 1,2,3,3,3. Asserting rst_ni low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Next-PC generator for the instruction frontend: tracks the fetch PC, issues I$ requests
// and picks the next address from redirects, replay, branch prediction or sequential advance.
module fetch_pc_gen #(
   parameter int unsigned VLEN        = 39,
   parameter int unsigned FETCH_BYTES = 4,
   parameter int unsigned NR_REDIRECT = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [VLEN-1:0]             boot_addr_i,
   input  logic                        halt_i,
   input  logic                        flush_i,
   input  logic [NR_REDIRECT-1:0]      redirect_valid_i,
   input  logic [NR_REDIRECT*VLEN-1:0] redirect_addr_i,
   input  logic                        replay_i,
   input  logic [VLEN-1:0]             replay_addr_i,
   input  logic                        bp_valid_i,
   input  logic [VLEN-1:0]             bp_addr_i,
   input  logic                        fetch_ready_i,
   output logic                        req_o,
   output logic [VLEN-1:0]             vaddr_o,
   input  logic                        req_ready_i,
   output logic                        kill_s1_o,
   output logic                        kill_s2_o,
   output logic [CNT_W-1:0]            redirect_cnt_o
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

   localparam logic [VLEN-1:0]  BLOCK_MASK = VLEN'(FETCH_BYTES - 1);
   localparam logic [VLEN-1:0]  BLOCK_STEP = VLEN'(FETCH_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_e           state, state_next;
   logic [VLEN-1:0]  pc, pc_next, redirect_target;
   logic [CNT_W-1:0] cnt;
   logic             redirect_any, kill_front, accepted;

   assign redirect_any = |redirect_valid_i;
   assign kill_front   = redirect_any | flush_i | replay_i;
   assign accepted     = req_o & req_ready_i;

   // Later (higher-index) channels overwrite earlier ones, giving them priority.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      redirect_target = '0;
      for (int k = 0; k < NR_REDIRECT; k++) begin
         if (redirect_valid_i[k]) redirect_target = redirect_addr_i[k*VLEN +: VLEN];
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= BOOT;
      end else begin
         // NOTE: state is updated with non-blocking assignments so all registers sample together.
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = halt_i ? HALT : RUN;
         RUN:     state_next = halt_i ? HALT : RUN;
         HALT:    state_next = halt_i ? HALT : RUN;
         default: state_next = BOOT;
      endcase
   end

   // Output logic; reset forces every output low even though kills are combinational.
   always_comb begin
      req_o     = 1'b0;
      vaddr_o   = pc;
      kill_s1_o = kill_front;
      kill_s2_o = kill_front | bp_valid_i;
      case (state)
         BOOT:    vaddr_o = boot_addr_i;
         RUN:     req_o   = fetch_ready_i & ~flush_i & ~halt_i;
         HALT:    req_o   = 1'b0;
         default: req_o   = 1'b0;
      endcase
      if (!rst_ni) begin
         req_o     = 1'b0;
         vaddr_o   = '0;
         kill_s1_o = 1'b0;
         kill_s2_o = 1'b0;
      end
   end

   // Next-PC priority: boot, redirect, replay, prediction, sequential step, hold.
   always_comb begin
      pc_next = pc;
      if (state == BOOT)     pc_next = boot_addr_i;
      else if (redirect_any) pc_next = redirect_target;
      else if (replay_i)     pc_next = replay_addr_i;
      else if (bp_valid_i)   pc_next = bp_addr_i;
      else if (accepted)     pc_next = (pc & ~BLOCK_MASK) + BLOCK_STEP;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc  <= '0;
         cnt <= '0;
      end else begin
         pc <= pc_next;
         if (state != BOOT && redirect_any && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
   end

   assign redirect_cnt_o = cnt;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vectors with literal expectations plus a
// per-cycle behavioural model of the fetch address sequence.
module tb_fetch_pc_gen;
   localparam int VLEN = 39;
   localparam int FB   = 8;
   localparam int NR   = 4;
   localparam int CW   = 2;
   localparam logic [63:0] VMASK = (64'd1 << VLEN) - 1;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [VLEN-1:0]    boot_addr, replay_addr, bp_addr;
   logic               halt, flush, replay, bp_valid, fetch_ready, req_ready;
   logic [NR-1:0]      rv;
   logic [VLEN-1:0]    rd_addr [NR];
   logic [NR*VLEN-1:0] redirect_addr;
   logic               req, kill_s1, kill_s2;
   logic [VLEN-1:0]    vaddr;
   logic [CW-1:0]      cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   always_comb begin
      for (int k = 0; k < NR; k++) redirect_addr[k*VLEN +: VLEN] = rd_addr[k];
   end

   fetch_pc_gen #(.VLEN(VLEN), .FETCH_BYTES(FB), .NR_REDIRECT(NR), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr), .halt_i(halt), .flush_i(flush),
      .redirect_valid_i(rv), .redirect_addr_i(redirect_addr), .replay_i(replay),
      .replay_addr_i(replay_addr), .bp_valid_i(bp_valid), .bp_addr_i(bp_addr),
      .fetch_ready_i(fetch_ready), .req_o(req), .vaddr_o(vaddr), .req_ready_i(req_ready),
      .kill_s1_o(kill_s1), .kill_s2_o(kill_s2), .redirect_cnt_o(cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: PC is a plain number; "halted" is just last cycle's halt_i; boot is the first cycle out of reset.
   bit          m_boot   = 1'b1;
   bit          m_halted = 1'b0;
   logic [63:0] m_pc     = '0;
   int          m_cnt    = 0;

   always @(negedge clk_i) begin
      logic        e_req, e_k1;
      logic [63:0] e_vaddr;
      int          hi;
      if (!rst_ni) begin
         check("model_rst_vaddr", 64'(vaddr), 64'd0);
         check("model_rst_req", 64'(req), 64'd0);
         check("model_rst_kill", 64'({kill_s1, kill_s2}), 64'd0);
         check("model_rst_cnt", 64'(cnt), 64'd0);
         m_boot = 1'b1; m_halted = 1'b0; m_pc = '0; m_cnt = 0;
      end else begin
         e_vaddr = m_boot ? 64'(boot_addr) : m_pc;
         e_req   = !m_boot && !m_halted && fetch_ready && !flush && !halt;
         e_k1    = (rv != '0) || flush || replay;
         check("model_vaddr", 64'(vaddr), e_vaddr);
         check("model_req", 64'(req), 64'(e_req));
         check("model_kill_s1", 64'(kill_s1), 64'(e_k1));
         check("model_kill_s2", 64'(kill_s2), 64'(e_k1 || bp_valid));
         check("model_cnt", 64'(cnt), 64'(m_cnt));
         hi = -1;
         for (int k = 0; k < NR; k++) if (rv[k]) hi = k;
         if (m_boot)               m_pc = 64'(boot_addr);
         else if (hi >= 0)         m_pc = 64'(rd_addr[hi]);
         else if (replay)          m_pc = 64'(replay_addr);
         else if (bp_valid)        m_pc = 64'(bp_addr);
         else if (e_req && req_ready) m_pc = ((m_pc / FB) * FB + FB) & VMASK;
         if (!m_boot && hi >= 0 && m_cnt < (1 << CW) - 1) m_cnt++;
         m_halted = halt;
         m_boot   = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      int exp_cnt [5] = '{1, 2, 3, 3, 3};
      rst_ni = 1'b0; boot_addr = VLEN'(64'h8000_0000); halt = 0; flush = 0; replay = 0;
      replay_addr = '0; bp_valid = 0; bp_addr = '0; fetch_ready = 1; req_ready = 1; rv = '0;
      for (int k = 0; k < NR; k++) rd_addr[k] = '0;
      #3;
      check("reset_vaddr", 64'(vaddr), 64'd0);
      check("reset_req", 64'(req), 64'd0);

      // Boot then sequential fetch in 8-byte blocks
      step(); rst_ni = 1'b1; #1;
      check("boot_req", 64'(req), 64'd0);
      check("boot_vaddr", 64'(vaddr), 64'h8000_0000);
      step(); check("seq0", 64'(vaddr), 64'h8000_0000); check("seq0_req", 64'(req), 64'd1);
      step(); check("seq1", 64'(vaddr), 64'h8000_0008);
      step(); check("seq2", 64'(vaddr), 64'h8000_0010);

      // Unaligned redirect on channel 1
      rv = 4'b0010; rd_addr[1] = VLEN'(64'h1006); #1;
      check("redir_kill_s1", 64'(kill_s1), 64'd1);
      step(); rv = '0; #1;
      check("redir_target", 64'(vaddr), 64'h1006);
      check("redir_cnt", 64'(cnt), 64'd1);
      step(); check("redir_aligned_step", 64'(vaddr), 64'h1008);

      // Channels 0 and 3 plus replay and prediction together
      rv = 4'b1001; rd_addr[0] = VLEN'(64'h100); rd_addr[3] = VLEN'(64'h300);
      replay = 1; replay_addr = VLEN'(64'h700); bp_valid = 1; bp_addr = VLEN'(64'h900);
      step(); rv = '0; replay = 0; bp_valid = 0; #1;
      check("prio_vaddr", 64'(vaddr), 64'h300);
      check("prio_cnt", 64'(cnt), 64'd2);

      // Stalled request, then prediction overrides the pending address
      rv = 4'b0001; rd_addr[0] = VLEN'(64'h2000);
      step(); rv = '0; req_ready = 0; #1;
      check("stall0", 64'(vaddr), 64'h2000); check("stall0_req", 64'(req), 64'd1);
      step(); check("stall1", 64'(vaddr), 64'h2000);
      step(); check("stall2", 64'(vaddr), 64'h2000);
      bp_valid = 1; bp_addr = VLEN'(64'h4000); #1;
      check("bp_kill_s2", 64'(kill_s2), 64'd1);
      check("bp_kill_s1", 64'(kill_s1), 64'd0);
      step(); bp_valid = 0; req_ready = 1; #1;
      check("bp_target", 64'(vaddr), 64'h4000);
      check("cnt_saturated", 64'(cnt), 64'd3);

      // Sequential wrap from the last block
      rv = 4'b0001; rd_addr[0] = VLEN'(VMASK - 64'd7);
      step(); rv = '0; #1;
      check("last_block", 64'(vaddr), VMASK - 64'd7);
      step(); check("wrap_to_zero", 64'(vaddr), 64'd0);

      // Redirect while halting
      halt = 1; rv = 4'b0100; rd_addr[2] = VLEN'(64'h500); #1;
      check("halt_req", 64'(req), 64'd0);
      step(); rv = '0; #1;
      check("halted_vaddr", 64'(vaddr), 64'h500);
      check("halted_req", 64'(req), 64'd0);
      halt = 0; #1;
      check("halt_exit_req", 64'(req), 64'd0);
      step(); check("resume_vaddr", 64'(vaddr), 64'h500); check("resume_req", 64'(req), 64'd1);

      // Flush alone: no request, PC holds
      flush = 1; #1;
      check("flush_req", 64'(req), 64'd0);
      check("flush_kill_s1", 64'(kill_s1), 64'd1);
      step(); flush = 0; #1;
      check("flush_hold", 64'(vaddr), 64'h500);

      // Asynchronous reset mid-stream
      rv = 4'b0001; rd_addr[0] = VLEN'(64'h40); #1;
      rst_ni = 0; #1;
      check("async_rst_vaddr", 64'(vaddr), 64'd0);
      check("async_rst_req", 64'(req), 64'd0);
      check("async_rst_kill", 64'({kill_s1, kill_s2}), 64'd0);
      check("async_rst_cnt", 64'(cnt), 64'd0);
      rv = '0;
      step(); step(); rst_ni = 1;
      step();

      // Saturating counter with CNT_W=2
      rv = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         rd_addr[0] = VLEN'(64'h1000 + 64'(i) * 64'h40);
         step();
         check($sformatf("cnt_seq%0d", i), 64'(cnt), 64'(exp_cnt[i]));
      end
      rv = '0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
